// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate extender: extend modes, pipe states and the branch shift.
// Imported by the interface, the arithmetic core and the top level.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGN   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_e;

  // Occupancy of the output pipe; FULL is reachable only in the skid build.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int BRANCH_SHIFT = 2;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Handshake bundle between decode (master) and the immediate extender (slave).
// Widths are parameters and must match the extender instance they are bound to.
interface imm_extend_unit_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
) ();

  // Valid/ready: a beat moves on a rising edge where valid && ready; the sender
  // holds its payload stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  ext_mode_e        in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational mode arithmetic: widens an IN_W immediate to OUT_W according to the mode.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_imm,
  input  ext_mode_e        i_mode,
  output logic [OUT_W-1:0] o_result
);

  localparam int N = OUT_W - IN_W;

  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;

  assign w_zero   = {{N{1'b0}}, i_imm};
  assign w_sign   = {{N{i_imm[IN_W-1]}}, i_imm};
  assign w_upper  = {i_imm, {N{1'b0}}};
  // Shifting at full width drops the two top bits of the sign-extended value.
  assign w_branch = w_sign << BRANCH_SHIFT;

  always_comb begin
    o_result = w_zero;
    unique case (i_mode)
      EXT_ZERO:   o_result = w_zero;
      EXT_SIGN:   o_result = w_sign;
      EXT_UPPER:  o_result = w_upper;
      EXT_BRANCH: o_result = w_branch;
      default:    o_result = w_zero;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender with one cycle of latency behind a valid/ready handshake.
// Build option IMM_EXT_SKID_EN: two-entry skid buffer with registered in_ready.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_extend_unit_if.slave  bus,
  output skid_state_e       o_dbg_state
);

  if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
    $error("imm_extend_unit: need IN_W >= 2 and OUT_W >= IN_W + 2");
  end

  logic [OUT_W-1:0] w_result;
  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main;
  logic [OUT_W-1:0] r_main_data;
  logic [TAG_W-1:0] r_main_tag;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .i_imm    (bus.in_imm),
    .i_mode   (bus.in_mode),
    .o_result (w_result)
  );

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_out_xfer  = w_out_valid && bus.out_ready;

`ifdef IMM_EXT_SKID_EN
  logic             r_in_ready;
  logic             w_load_skid;
  logic             w_skid_to_main;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;

  assign w_in_ready = r_in_ready;
`else
  assign w_in_ready = !w_out_valid || bus.out_ready;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
`ifdef IMM_EXT_SKID_EN
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
`endif
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
`ifdef IMM_EXT_SKID_EN
        end else if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
`endif
        end
      end
`ifdef IMM_EXT_SKID_EN
      ST_FULL: begin
        if (w_out_xfer) begin
          w_state_nxt    = ST_ONE;
          w_skid_to_main = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef IMM_EXT_SKID_EN
  // Ready is decided from the next state so it never depends on this cycle's out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_data <= '0;
      r_skid_tag  <= '0;
    end else if (w_load_skid) begin
      r_skid_data <= w_result;
      r_skid_tag  <= bus.in_tag;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_tag  <= '0;
    end else if (w_load_main) begin
      r_main_data <= w_result;
      r_main_tag  <= bus.in_tag;
`ifdef IMM_EXT_SKID_EN
    end else if (w_skid_to_main) begin
      r_main_data <= r_skid_data;
      r_main_tag  <= r_skid_tag;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_tag   = r_main_tag;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed cases, back-pressure, random stream, reset.
module tb_imm_extend_unit;
  import imm_ext_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   n_out    = 0;
  logic [63:0] exp_q[$];

  imm_extend_unit_if #(.IN_W(16), .OUT_W(32), .TAG_W(4)) u_if ();
  imm_extend_unit_if #(.IN_W(12), .OUT_W(20), .TAG_W(4)) b_if ();
  skid_state_e dbg_state;
  skid_state_e dbg_state_b;

  imm_extend_unit #(.IN_W(16), .OUT_W(32), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if), .o_dbg_state(dbg_state)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(20), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if), .o_dbg_state(dbg_state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- checking ----------------
  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: treat the immediate as a number and apply each mode's arithmetic modulo 2^out_w.
  function automatic logic [63:0] ref_ext(input int in_w, input int out_w,
                                          input logic [31:0] imm, input int mode);
    longint v;
    longint sv;
    longint r;
    v  = longint'(imm);
    sv = (v >= (longint'(1) << (in_w - 1))) ? v - (longint'(1) << in_w) : v;
    case (mode)
      0:       r = v;
      1:       r = sv;
      2:       r = v * (longint'(1) << (out_w - in_w));
      default: r = sv * 4;
    endcase
    r = r & ((longint'(1) << out_w) - 1);
    return 64'(r);
  endfunction

  // Producer rule: a beat offered but not taken must be unchanged at the next edge.
  logic        p_hold;
  logic [21:0] p_bits;
  always @(posedge clk) begin
    if (rst_n && p_hold)
      assert ({u_if.in_imm, u_if.in_mode, u_if.in_tag} == p_bits)
      else $error("producer changed a held beat");
    p_hold <= u_if.in_valid && !u_if.in_ready;
    p_bits <= {u_if.in_imm, u_if.in_mode, u_if.in_tag};
  end

  // ---------------- scoreboard monitor ----------------
  logic        p_stall = 1'b0;
  logic [35:0] p_out;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check_eq("hold_valid", 64'(u_if.out_valid), 64'd1);
        check_eq("hold_payload", 64'({u_if.out_tag, u_if.out_data}), 64'(p_out));
      end
      if (u_if.in_valid && u_if.in_ready) begin
        e = ref_ext(16, 32, 32'(u_if.in_imm), int'(u_if.in_mode));
        exp_q.push_back(64'({u_if.in_tag, e[31:0]}));
        n_acc++;
      end
      if (u_if.out_valid && u_if.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check_eq("unexpected_beat", 64'({u_if.out_tag, u_if.out_data}), 64'hDEAD_0000_0000);
        else check_eq("beat", 64'({u_if.out_tag, u_if.out_data}), exp_q.pop_front());
      end
      p_stall = u_if.out_valid && !u_if.out_ready;
      p_out   = {u_if.out_tag, u_if.out_data};
    end
  end

  // ---------------- driver tasks ----------------
  // Offers one beat from posedge+1 and returns at posedge+1 after the edge that took it.
  task automatic drive_beat(input logic [15:0] imm, input ext_mode_e mode, input logic [3:0] tag);
    logic acc;
    int   budget;
    u_if.in_valid = 1'b1;
    u_if.in_imm   = imm;
    u_if.in_mode  = mode;
    u_if.in_tag   = tag;
    budget = 0;
    do begin
      @(negedge clk);
      acc = u_if.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int budget;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() != 0 || u_if.out_valid) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("drain_out_valid", 64'(u_if.out_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, base_acc, base_out, sent;
    logic acc;
    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_imm    = '0;
    u_if.in_mode   = EXT_ZERO;
    u_if.in_tag    = '0;
    u_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b0;
    b_if.in_imm    = '0;
    b_if.in_mode   = EXT_ZERO;
    b_if.in_tag    = '0;
    b_if.out_ready = 1'b1;

    #12;
    check_eq("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check_eq("rst_out_data", 64'(u_if.out_data), 64'd0);
    check_eq("rst_out_tag", 64'(u_if.out_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 64'(u_if.in_ready), 64'd1);

    // Directed modes, 16 -> 32
    check_eq("pre_accept_valid", 64'(u_if.out_valid), 64'd0);
    drive_beat(16'h8001, EXT_SIGN, 4'h1);
    check_eq("lat_valid_sign", 64'(u_if.out_valid), 64'd1);
    check_eq("sign_8001", 64'(u_if.out_data), 64'hFFFF8001);
    drive_beat(16'h8001, EXT_ZERO, 4'h2);
    check_eq("lat_valid_zero", 64'(u_if.out_valid), 64'd1);
    check_eq("zero_8001", 64'(u_if.out_data), 64'h00008001);
    drive_beat(16'h1234, EXT_UPPER, 4'h3);
    check_eq("upper_1234", 64'(u_if.out_data), 64'h12340000);
    drive_beat(16'hFFFF, EXT_BRANCH, 4'h4);
    check_eq("branch_ffff", 64'(u_if.out_data), 64'hFFFFFFFC);
    drive_beat(16'h7FFF, EXT_BRANCH, 4'h5);
    check_eq("branch_7fff", 64'(u_if.out_data), 64'h0001FFFC);
    check_eq("branch_tag", 64'(u_if.out_tag), 64'h5);
    wait_drain();

    // Narrow instance, 12 -> 20
    check_eq("b_in_ready", 64'(b_if.in_ready), 64'd1);
    b_if.in_valid = 1'b1;
    b_if.in_imm   = 12'h800;
    b_if.in_mode  = EXT_SIGN;
    b_if.in_tag   = 4'h9;
    @(posedge clk); #1;
    check_eq("b_sign_800", 64'(b_if.out_data), 64'hFF800);
    check_eq("b_sign_tag", 64'(b_if.out_tag), 64'h9);
    b_if.in_imm  = 12'hABC;
    b_if.in_mode = EXT_UPPER;
    @(posedge clk); #1;
    check_eq("b_upper_abc", 64'(b_if.out_data), 64'hABC00);
    b_if.in_valid = 1'b0;

    // Back-pressure: tags 1..6 while out_ready is low for 5 cycles
    base_acc = n_acc;
    base_out = n_out;
    fork
      begin
        for (int t = 1; t <= 6; t++)
          drive_beat(16'($urandom), ext_mode_e'($urandom_range(0, 3)), 4'(t));
        u_if.in_valid = 1'b0;
      end
      begin
        u_if.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`ifdef IMM_EXT_SKID_EN
        check_eq("bp_accepted", 64'(n_acc - base_acc), 64'd2);
        check_eq("bp_state_full", 64'(dbg_state), 64'(ST_FULL));
`else
        check_eq("bp_accepted", 64'(n_acc - base_acc), 64'd1);
`endif
        check_eq("bp_in_ready", 64'(u_if.in_ready), 64'd0);
        u_if.out_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("bp_out_count", 64'(n_out - base_out), 64'd6);

    // Full throughput with both handshakes held high
    u_if.out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 40; i++)
      drive_beat(16'($urandom), ext_mode_e'($urandom_range(0, 3)), 4'($urandom));
    check_eq("throughput_cycles", 64'(cyc - c0), 64'd40);
    wait_drain();

    // Random valid/ready stream
    sent = 0;
    c0 = cyc;
    u_if.in_valid = 1'b0;
    while (sent < 10000 && cyc - c0 < 80000) begin
      @(negedge clk);
      acc = u_if.in_valid && u_if.in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
      if (acc || !u_if.in_valid) begin
        u_if.in_valid = ($urandom_range(0, 3) != 0) && (sent < 10000);
        if (u_if.in_valid) begin
          u_if.in_imm  = 16'($urandom);
          u_if.in_mode = ext_mode_e'($urandom_range(0, 3));
          u_if.in_tag  = 4'($urandom);
        end
      end
      u_if.out_ready = ($urandom_range(0, 3) != 0);
    end
    check_eq("random_sent", 64'(sent), 64'd10000);
    wait_drain();

    // Asynchronous reset with beats held
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_imm    = 16'hA5A5;
    u_if.in_mode   = EXT_SIGN;
    u_if.in_tag    = 4'hC;
    repeat (3) @(posedge clk);
    #1;
`ifdef IMM_EXT_SKID_EN
    check_eq("pre_rst_full", 64'(dbg_state), 64'(ST_FULL));
`endif
    check_eq("pre_rst_valid", 64'(u_if.out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    u_if.in_valid = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(u_if.out_valid), 64'd0);
    check_eq("arst_out_data", 64'(u_if.out_data), 64'd0);
    check_eq("arst_out_tag", 64'(u_if.out_tag), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", 64'(u_if.in_ready), 64'd1);
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("no_stale", 64'(u_if.out_valid), 64'd0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
